csr_file_trap: RTL and testbench
================================

Name: csr_file_trap

Overview:
Parametrised machine-mode CSR file with trap sequencing for the single-hart core.
- Replaces the fixed-function CSR register file.
- Adds programmable mcause/mtval, mscratch, mie/mip, timer interrupt entry, vectored mtvec, 64-bit cycle/instret counters and illegal-CSR detection.
- Sits beside the EXU: receives retire-time trap/mret events and CSR read/write requests; returns read data and a PC redirect.

Parameters:
XLEN, 32, data width of all CSRs
VENDOR_ID, 32'h79737978, mvendorid value
ARCH_ID, 32'h23060124, marchid value
CNT_W, 64, counter width; low half at 0xB00/0xB02, high half at 0xB80/0xB82

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
i_csr_ren  in  1  CSR read request (qualifies illegal check)
i_csr_raddr  in  12  read address
o_csr_rdata  out  XLEN  combinational read data
i_csr_wen  in  1  CSR write
i_csr_waddr  in  12  write address
i_csr_wdata  in  XLEN  write data
o_csr_illegal  out  1  access to unimplemented CSR, or write to read-only CSR
i_ecall  in  1  ecall retiring
i_illegal  in  1  illegal instruction retiring
i_mret  in  1  mret retiring
i_pc  in  XLEN  PC of retiring instruction
i_tval  in  XLEN  faulting instruction bits
i_instret  in  1  one instruction retired this cycle
i_irq_ok  in  1  core at an instruction boundary; interrupt may be taken
i_mtip  in  1  timer interrupt level from CLINT
o_redirect  out  1  PC redirect this cycle
o_trap_pc  out  XLEN  redirect target

Behaviour:
Reset values:
- mstatus = 0x00001800 (MPP = M).
- mepc, mtvec, mcause, mtval, mscratch, mie = 0.
- Counters = 0.
- All outputs are combinational from state and inputs. With all inputs 0 after reset: o_redirect = 0, o_trap_pc = 0.

Event priority per cycle: illegal > ecall > interrupt > mret > CSR write. Only the highest-priority event updates state.

Exception entry:
- mepc = i_pc.
- mcause = 2 (illegal) or 11 (ecall).
- mtval = i_tval (illegal) or 0 (ecall).
- MPIE = MIE, MIE = 0, MPP = 2'b11.
- o_trap_pc = {mtvec[XLEN-1:2], 2'b00}.

Interrupt:
- irq_take = i_irq_ok & mstatus.MIE & mie[7] & mip[7] & no exception this cycle.
- mip[7] mirrors i_mtip each cycle; it is read-only.
- mepc = i_pc; mcause = {1'b1, 31'd7}; mtval = 0; MIE/MPIE/MPP update as for exception entry.
- Target: base + 28 if mtvec[1:0] == 1 (vectored), otherwise base.

mret:
- MIE = MPIE, MPIE = 1, MPP = 2'b11 (M-only core).
- o_trap_pc = mepc.

o_redirect = exception | irq_take | mret.
- o_trap_pc is valid only while o_redirect = 1, and 0 otherwise.

CSR write:
- Takes effect at the next edge. A read in the same cycle returns the old value (no bypass).
- A write in a cycle with any trap or mret is dropped.
- mtvec[1:0] values 2 and 3 are written as 0.
- mstatus writable bits: 3, 7. MPP is hardwired 11. All other bits read 0.
- mie writable bit: 7 only.

Counters:
- mcycle increments every cycle.
- minstret increments when i_instret = 1.
- A CSR write to either half replaces the whole counter's next value in that cycle; there is no increment that cycle.
- Counters wrap from all-ones to 0.

Read map:
- Read/write: 0x300 mstatus, 0x304 mie, 0x305 mtvec, 0x340 mscratch, 0x341 mepc, 0x342 mcause, 0x343 mtval.
- Read-only: 0x344 mip, 0xF11 mvendorid, 0xF12 marchid.
- Counters: per CNT_W above.
- Any other address reads 0.
- o_csr_illegal = (ren & unmapped) | (wen & (unmapped | waddr[11:10] == 2'b11)).
- An illegal write is ignored.

Reset mid-operation: reset overrides all events that cycle.

Optional Feature:
CSR_COUNTERS_EN:
- Defined: mcycle/minstret (0xB00/0xB02/0xB80/0xB82) are implemented as above.
- Undefined: counter registers are absent; those addresses are unmapped (read 0, flag o_csr_illegal); i_instret is ignored.

Decomposition:
Shared package csr_pkg holds:
- CSR address localparams.
- mstatus bit indices (MIE = 3, MPIE = 7, MPP = 12:11).
- Cause codes (CAUSE_ILLEGAL = 2, CAUSE_ECALL = 11, CAUSE_MTI = 7).
- mtvec mode encodings.

Sub-module csr_counter: one CNT_W-bit counter with increment enable and half-word write port, instantiated twice.

Test Plan:
1. Reset, then read 0x300/0xF11/0xF12 -> 0x00001800 / 0x79737978 / 0x23060124; o_redirect = 0.
2. Write mtvec = 0x80000100; ecall at pc 0x80000040 -> same cycle o_redirect = 1, o_trap_pc = 0x80000100. Next cycle: mepc = 0x80000040, mcause = 11, MIE = 0.
3. Set MIE, mie[7], mtvec = 0x80000101; hold i_mtip = 1 with i_irq_ok = 1 -> o_trap_pc = 0x8000011C, mcause = 0x80000007. Then mret -> o_trap_pc = mepc, MIE = 1.
4. i_illegal and i_ecall in the same cycle as i_csr_wen to mscratch -> mcause = 2, mtval = i_tval, mscratch unchanged.
5. Write mcycle low = 0xFFFFFFFF, high = 0 -> after 1 cycle high = 1, low = 0. Pulse i_instret ×3 -> minstret = 3.
6. Read 0x7C0, and write 0xF11 -> o_csr_illegal = 1 for both; read data 0; 0xF11 unchanged.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared CSR addresses, mstatus bit positions, cause codes and mtvec modes.
// Counter CSRs are only mapped when CSR_COUNTERS_EN is defined.
package csr_pkg;

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MIE_MTIE       = 7;

    localparam logic [4:0] CAUSE_ILLEGAL = 5'd2;
    localparam logic [4:0] CAUSE_ECALL   = 5'd11;
    localparam logic [4:0] CAUSE_MTI     = 5'd7;

    typedef enum logic [1:0] {
        MTVEC_DIRECT   = 2'b00,
        MTVEC_VECTORED = 2'b01
    } mtvecMode_e;

    function automatic logic csrMapped(input logic [11:0] addr);
        case (addr)
            ADDR_MSTATUS, ADDR_MIE, ADDR_MTVEC, ADDR_MSCRATCH, ADDR_MEPC,
            ADDR_MCAUSE, ADDR_MTVAL, ADDR_MIP, ADDR_MVENDORID, ADDR_MARCHID:
                csrMapped = 1'b1;
`ifdef CSR_COUNTERS_EN
            ADDR_MCYCLE, ADDR_MINSTRET, ADDR_MCYCLEH, ADDR_MINSTRETH:
                csrMapped = 1'b1;
`endif
            default:
                csrMapped = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter.sv
// One wide free-running counter whose low or high half can be overwritten.
// Used for mcycle/minstret when CSR_COUNTERS_EN is defined.
module csr_counter
    import csr_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_wenLo,
    input  logic             i_wenHi,
    input  logic [XLEN-1:0]  i_wdata,
    output logic [CNT_W-1:0] o_count
);

    localparam int HI_W = CNT_W - XLEN;

    logic [CNT_W-1:0] r_count;

    // A half-word write replaces the whole next value, so it suppresses the increment.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_wenLo) begin
            r_count <= {r_count[CNT_W-1:XLEN], i_wdata};
        end else if (i_wenHi) begin
            r_count <= {i_wdata[HI_W-1:0], r_count[XLEN-1:0]};
        end else if (i_inc) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/csr_file_trap.sv
// Machine-mode CSR file with exception/interrupt/mret sequencing.
// Define CSR_COUNTERS_EN to implement the mcycle/minstret counters.
module csr_file_trap
    import csr_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] VENDOR_ID = 32'h79737978,
    parameter logic [XLEN-1:0] ARCH_ID   = 32'h23060124,
    parameter int              CNT_W     = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            i_csr_ren,
    input  logic [11:0]     i_csr_raddr,
    output logic [XLEN-1:0] o_csr_rdata,
    input  logic            i_csr_wen,
    input  logic [11:0]     i_csr_waddr,
    input  logic [XLEN-1:0] i_csr_wdata,
    output logic            o_csr_illegal,
    input  logic            i_ecall,
    input  logic            i_illegal,
    input  logic            i_mret,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_tval,
    input  logic            i_instret,
    input  logic            i_irq_ok,
    input  logic            i_mtip,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_trap_pc
);

    logic            r_mie;
    logic            r_mpie;
    logic            r_mtie;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mtval;
    logic [XLEN-1:0] r_mscratch;

    logic             w_exc;
    logic             w_irqTake;
    logic             w_wrIllegal;
    logic             w_wrOk;
    logic [XLEN-1:0]  w_base;
    logic [XLEN-1:0]  w_mstatus;
    logic [XLEN-1:0]  w_mtvecWr;
    logic [CNT_W-1:0] w_mcycle;
    logic [CNT_W-1:0] w_minstret;

    assign w_exc       = i_illegal | i_ecall;
    assign w_irqTake   = i_irq_ok & r_mie & r_mtie & i_mtip & ~w_exc;
    assign w_wrIllegal = ~csrMapped(i_csr_waddr) | (i_csr_waddr[11:10] == 2'b11);
    assign w_wrOk      = i_csr_wen & ~w_wrIllegal & ~(w_exc | w_irqTake | i_mret);
    assign w_base      = {r_mtvec[XLEN-1:2], 2'b00};
    assign w_mtvecWr   = (i_csr_wdata[1:0] == MTVEC_VECTORED) ? i_csr_wdata
                       : {i_csr_wdata[XLEN-1:2], MTVEC_DIRECT};

    assign o_csr_illegal = (i_csr_ren & ~csrMapped(i_csr_raddr)) | (i_csr_wen & w_wrIllegal);
    assign o_redirect    = w_exc | w_irqTake | i_mret;

    always_comb begin
        w_mstatus = '0;
        w_mstatus[MSTATUS_MIE] = r_mie;
        w_mstatus[MSTATUS_MPIE] = r_mpie;
        w_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    always_comb begin
        o_trap_pc = '0;
        if (w_exc) begin
            o_trap_pc = w_base;
        end else if (w_irqTake) begin
            o_trap_pc = (r_mtvec[1:0] == MTVEC_VECTORED) ? w_base + XLEN'({CAUSE_MTI, 2'b00}) : w_base;
        end else if (i_mret) begin
            o_trap_pc = r_mepc;
        end
    end

    // Only the highest-priority event touches state; CSR writes lose to any trap or mret.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_mtie     <= 1'b0;
            r_mepc     <= '0;
            r_mtvec    <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
            r_mscratch <= '0;
        end else if (w_exc) begin
            r_mepc   <= i_pc;
            r_mcause <= {{(XLEN-5){1'b0}}, (i_illegal ? CAUSE_ILLEGAL : CAUSE_ECALL)};
            r_mtval  <= i_illegal ? i_tval : '0;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
        end else if (w_irqTake) begin
            r_mepc   <= i_pc;
            r_mcause <= {1'b1, {(XLEN-6){1'b0}}, CAUSE_MTI};
            r_mtval  <= '0;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
        end else if (i_mret) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
        end else if (w_wrOk) begin
            case (i_csr_waddr)
                ADDR_MSTATUS: begin
                    r_mie  <= i_csr_wdata[MSTATUS_MIE];
                    r_mpie <= i_csr_wdata[MSTATUS_MPIE];
                end
                ADDR_MIE:      r_mtie     <= i_csr_wdata[MIE_MTIE];
                ADDR_MTVEC:    r_mtvec    <= w_mtvecWr;
                ADDR_MSCRATCH: r_mscratch <= i_csr_wdata;
                ADDR_MEPC:     r_mepc     <= i_csr_wdata;
                ADDR_MCAUSE:   r_mcause   <= i_csr_wdata;
                ADDR_MTVAL:    r_mtval    <= i_csr_wdata;
                default: ;
            endcase
        end
    end

`ifdef CSR_COUNTERS_EN
    csr_counter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_mcycle (
        .clock   (clock),
        .reset   (reset),
        .i_inc   (1'b1),
        .i_wenLo (w_wrOk & (i_csr_waddr == ADDR_MCYCLE)),
        .i_wenHi (w_wrOk & (i_csr_waddr == ADDR_MCYCLEH)),
        .i_wdata (i_csr_wdata),
        .o_count (w_mcycle)
    );

    csr_counter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_minstret (
        .clock   (clock),
        .reset   (reset),
        .i_inc   (i_instret),
        .i_wenLo (w_wrOk & (i_csr_waddr == ADDR_MINSTRET)),
        .i_wenHi (w_wrOk & (i_csr_waddr == ADDR_MINSTRETH)),
        .i_wdata (i_csr_wdata),
        .o_count (w_minstret)
    );
`else
    logic w_unusedInstret;
    assign w_unusedInstret = i_instret;
    assign w_mcycle        = '0;
    assign w_minstret      = '0;
`endif

    always_comb begin
        o_csr_rdata = '0;
        case (i_csr_raddr)
            ADDR_MSTATUS:   o_csr_rdata = w_mstatus;
            ADDR_MIE:       o_csr_rdata[MIE_MTIE] = r_mtie;
            ADDR_MTVEC:     o_csr_rdata = r_mtvec;
            ADDR_MSCRATCH:  o_csr_rdata = r_mscratch;
            ADDR_MEPC:      o_csr_rdata = r_mepc;
            ADDR_MCAUSE:    o_csr_rdata = r_mcause;
            ADDR_MTVAL:     o_csr_rdata = r_mtval;
            ADDR_MIP:       o_csr_rdata[MIE_MTIE] = i_mtip;
            ADDR_MVENDORID: o_csr_rdata = VENDOR_ID;
            ADDR_MARCHID:   o_csr_rdata = ARCH_ID;
`ifdef CSR_COUNTERS_EN
            ADDR_MCYCLE:    o_csr_rdata = w_mcycle[XLEN-1:0];
            ADDR_MINSTRET:  o_csr_rdata = w_minstret[XLEN-1:0];
            ADDR_MCYCLEH:   o_csr_rdata = XLEN'(w_mcycle[CNT_W-1:XLEN]);
            ADDR_MINSTRETH: o_csr_rdata = XLEN'(w_minstret[CNT_W-1:XLEN]);
`endif
            default:        o_csr_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_csr_file_trap.sv
// Directed self-checking bench for csr_file_trap; counter checks follow CSR_COUNTERS_EN.
module tb_csr_file_trap;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_csr_ren;
    logic [11:0] i_csr_raddr;
    logic [31:0] o_csr_rdata;
    logic        i_csr_wen;
    logic [11:0] i_csr_waddr;
    logic [31:0] i_csr_wdata;
    logic        o_csr_illegal;
    logic        i_ecall;
    logic        i_illegal;
    logic        i_mret;
    logic [31:0] i_pc;
    logic [31:0] i_tval;
    logic        i_instret;
    logic        i_irq_ok;
    logic        i_mtip;
    logic        o_redirect;
    logic [31:0] o_trap_pc;

    int checks = 0;
    int errors = 0;

    csr_file_trap dut (
        .clock         (clock),
        .reset         (reset),
        .i_csr_ren     (i_csr_ren),
        .i_csr_raddr   (i_csr_raddr),
        .o_csr_rdata   (o_csr_rdata),
        .i_csr_wen     (i_csr_wen),
        .i_csr_waddr   (i_csr_waddr),
        .i_csr_wdata   (i_csr_wdata),
        .o_csr_illegal (o_csr_illegal),
        .i_ecall       (i_ecall),
        .i_illegal     (i_illegal),
        .i_mret        (i_mret),
        .i_pc          (i_pc),
        .i_tval        (i_tval),
        .i_instret     (i_instret),
        .i_irq_ok      (i_irq_ok),
        .i_mtip        (i_mtip),
        .o_redirect    (o_redirect),
        .o_trap_pc     (o_trap_pc)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one edge and settle 1ns after it so checks never sit on the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic readCsr(input logic [11:0] addr, output logic [31:0] data);
        i_csr_ren   = 1'b1;
        i_csr_raddr = addr;
        #1;
        data      = o_csr_rdata;
        i_csr_ren = 1'b0;
    endtask

    task automatic checkCsr(input string tag, input logic [11:0] addr, input logic [31:0] expected);
        logic [31:0] data;
        readCsr(addr, data);
        checkOutput(tag, 64'(data), 64'(expected));
    endtask

    task automatic applyStimulus(input logic [11:0] addr, input logic [31:0] data);
        i_csr_wen   = 1'b1;
        i_csr_waddr = addr;
        i_csr_wdata = data;
        tick();
        i_csr_wen = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        i_csr_ren = 0; i_csr_raddr = 0; i_csr_wen = 0; i_csr_waddr = 0; i_csr_wdata = 0;
        i_ecall = 0; i_illegal = 0; i_mret = 0; i_pc = 0; i_tval = 0;
        i_instret = 0; i_irq_ok = 0; i_mtip = 0;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset state
        checkCsr("rst_mstatus", 12'h300, 32'h00001800);
        checkCsr("rst_vendor", 12'hF11, 32'h79737978);
        checkCsr("rst_arch", 12'hF12, 32'h23060124);
        checkCsr("rst_mtvec", 12'h305, 32'h0);
        checkOutput("rst_redirect", 64'(o_redirect), 64'd0);
        checkOutput("rst_trap_pc", 64'(o_trap_pc), 64'd0);

        // ecall entry
        applyStimulus(12'h305, 32'h80000100);
        checkCsr("mtvec_wr", 12'h305, 32'h80000100);
        i_ecall = 1; i_pc = 32'h80000040;
        #1;
        checkOutput("ecall_redirect", 64'(o_redirect), 64'd1);
        checkOutput("ecall_trap_pc", 64'(o_trap_pc), 64'h80000100);
        tick();
        i_ecall = 0;
        checkCsr("ecall_mepc", 12'h341, 32'h80000040);
        checkCsr("ecall_mcause", 12'h342, 32'd11);
        checkCsr("ecall_mtval", 12'h343, 32'h0);
        checkCsr("ecall_mstatus", 12'h300, 32'h00001800);

        // Timer interrupt, vectored
        applyStimulus(12'h300, 32'hFFFFFFFF);
        checkCsr("mstatus_wr", 12'h300, 32'h00001888);
        applyStimulus(12'h300, 32'h00000008);
        applyStimulus(12'h304, 32'hFFFFFFFF);
        checkCsr("mie_wr", 12'h304, 32'h00000080);
        applyStimulus(12'h305, 32'h80000101);
        i_mtip = 1; i_pc = 32'h80000200;
        tick();
        #1;
        checkOutput("irq_blocked", 64'(o_redirect), 64'd0);
        checkCsr("mip_rd", 12'h344, 32'h00000080);
        i_irq_ok = 1;
        #1;
        checkOutput("irq_redirect", 64'(o_redirect), 64'd1);
        checkOutput("irq_trap_pc", 64'(o_trap_pc), 64'h8000011C);
        tick();
        i_irq_ok = 0; i_mtip = 0;
        checkCsr("irq_mcause", 12'h342, 32'h80000007);
        checkCsr("irq_mepc", 12'h341, 32'h80000200);
        checkCsr("irq_mstatus", 12'h300, 32'h00001880);
        i_mret = 1;
        #1;
        checkOutput("mret_redirect", 64'(o_redirect), 64'd1);
        checkOutput("mret_trap_pc", 64'(o_trap_pc), 64'h80000200);
        tick();
        i_mret = 0;
        #1;
        checkOutput("idle_trap_pc", 64'(o_trap_pc), 64'd0);
        checkCsr("mret_mstatus", 12'h300, 32'h00001888);

        // illegal beats ecall, and the same-cycle write is dropped
        applyStimulus(12'h340, 32'h12345678);
        i_illegal = 1; i_ecall = 1; i_pc = 32'h80000300; i_tval = 32'hDEADBEEF;
        i_csr_wen = 1; i_csr_waddr = 12'h340; i_csr_wdata = 32'hCAFEF00D;
        #1;
        checkOutput("exc_trap_pc", 64'(o_trap_pc), 64'h80000100);
        tick();
        i_illegal = 0; i_ecall = 0; i_csr_wen = 0;
        checkCsr("ill_mcause", 12'h342, 32'd2);
        checkCsr("ill_mtval", 12'h343, 32'hDEADBEEF);
        checkCsr("ill_mscratch", 12'h340, 32'h12345678);
        checkCsr("ill_mstatus", 12'h300, 32'h00001880);

        // mtvec modes 2/3 collapse to direct
        applyStimulus(12'h305, 32'h80000103);
        checkCsr("mtvec_mode3", 12'h305, 32'h80000100);

`ifdef CSR_COUNTERS_EN
        applyStimulus(12'hB00, 32'hFFFFFFFF);
        applyStimulus(12'hB80, 32'h0);
        tick();
        checkCsr("mcycle_lo_wrap", 12'hB00, 32'h0);
        checkCsr("mcycle_hi_carry", 12'hB80, 32'h1);
        applyStimulus(12'hB02, 32'h0);
        applyStimulus(12'hB82, 32'h0);
        i_instret = 1;
        tick(); tick(); tick();
        i_instret = 0;
        tick();
        checkCsr("minstret_lo", 12'hB02, 32'd3);
        checkCsr("minstret_hi", 12'hB82, 32'd0);
`else
        i_csr_ren = 1; i_csr_raddr = 12'hB00;
        #1;
        checkOutput("cnt_absent_ill", 64'(o_csr_illegal), 64'd1);
        checkOutput("cnt_absent_rd", 64'(o_csr_rdata), 64'd0);
        i_csr_ren = 0;
`endif

        // Illegal CSR accesses
        i_csr_ren = 1; i_csr_raddr = 12'h300;
        #1;
        checkOutput("legal_rd_flag", 64'(o_csr_illegal), 64'd0);
        i_csr_raddr = 12'h7C0;
        #1;
        checkOutput("unmapped_rd_flag", 64'(o_csr_illegal), 64'd1);
        checkOutput("unmapped_rd_data", 64'(o_csr_rdata), 64'd0);
        i_csr_ren = 0;
        i_csr_wen = 1; i_csr_waddr = 12'hF11; i_csr_wdata = 32'h11111111;
        #1;
        checkOutput("ro_wr_flag", 64'(o_csr_illegal), 64'd1);
        tick();
        i_csr_wen = 0;
        checkCsr("ro_wr_kept", 12'hF11, 32'h79737978);

        // Reset overrides a same-cycle ecall
        reset = 1; i_ecall = 1; i_pc = 32'h80000500;
        tick();
        reset = 0; i_ecall = 0;
        checkCsr("rst_mid_mepc", 12'h341, 32'h0);
        checkCsr("rst_mid_mstatus", 12'h300, 32'h00001800);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
